// File: rtl/yolo_pkg.sv
// Shared definitions for the yolo feature-map datapath: fp32 width, per-layer
// default geometry and the packer FSM state type.
package yolo_pkg;

  localparam int unsigned FP_WIDTH = 32;

  // Per-layer defaults for the featuremap producers.
  localparam int unsigned LAYER1_NUM_CH   = 32;
  localparam int unsigned LAYER1_IMG_SIZE = 104;
  localparam int unsigned LAYER2_NUM_CH   = 64;
  localparam int unsigned LAYER2_IMG_SIZE = 52;
  localparam int unsigned LAYER3_NUM_CH   = 128;
  localparam int unsigned LAYER3_IMG_SIZE = 26;

  localparam int unsigned DEFAULT_NUM_CH   = LAYER1_NUM_CH;
  localparam int unsigned DEFAULT_IMG_SIZE = LAYER1_IMG_SIZE;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } fm_state_e;

endpackage

// File: rtl/featuremap_channel_packer_if.sv
// Channel-serial input / channel-parallel output bus of the feature-map packer.
interface featuremap_channel_packer_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_IN_WIDTH = 1024
);

  logic [DATA_WIDTH-1:0]    data_in;
  logic                     valid_in;
  logic                     sof_in;
  logic [DATA_IN_WIDTH-1:0] data_out;
  logic                     valid_out;
  logic                     frame_done;
  logic                     err_partial;

  // master: upstream producer / consumer side; slave: the packer itself.
  modport master (
    output data_in, valid_in, sof_in,
    input  data_out, valid_out, frame_done, err_partial
  );

  modport slave (
    input  data_in, valid_in, sof_in,
    output data_out, valid_out, frame_done, err_partial
  );

endinterface

// File: rtl/featuremap_lane_collector.sv
// Channel counter and collection register; presents the assembled word
// (including the current beat) together with a word-complete strobe.
module featuremap_lane_collector #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumCh     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       valid_i,
  input  logic                       sof_i,
  output logic                       word_done_o,
  output logic                       drop_o,
  output logic [DataWidth*NumCh-1:0] word_o
);

  localparam int unsigned    ChW    = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam logic [ChW-1:0] ChLast = ChW'(NumCh - 1);

  logic [ChW-1:0]                  ch_cnt_q, ch_cnt_d, lane_sel;
  logic [NumCh-1:0][DataWidth-1:0] coll_q, coll_d;

  // A start-of-frame beat always lands in lane 0, whatever ch_cnt says.
  always_comb begin
    lane_sel = sof_i ? '0 : ch_cnt_q;
    ch_cnt_d = ch_cnt_q;
    if (valid_i) begin
      if (sof_i) begin
        ch_cnt_d = ChW'(1);
      end else if (ch_cnt_q == ChLast) begin
        ch_cnt_d = '0;
      end else begin
        ch_cnt_d = ch_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    coll_d = coll_q;
    if (valid_i) begin
      coll_d[lane_sel] = data_i;
    end
  end

  assign word_done_o = valid_i && !sof_i && (ch_cnt_q == ChLast);
  assign drop_o      = valid_i && sof_i && (ch_cnt_q != '0);
  assign word_o      = coll_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ch_cnt_q <= '0;
      coll_q   <= '0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      coll_q   <= coll_d;
    end
  end

endmodule

// File: rtl/featuremap_channel_packer.sv
// Packs NUM_CH channel-serial fp32 beats into one channel-parallel word.
// Define FEATUREMAP_PACKER_FRAME_CNT_EN to enable pixel counting and frame_done.
module featuremap_channel_packer
  import yolo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FP_WIDTH,
  parameter int unsigned NUM_CH        = DEFAULT_NUM_CH,
  parameter int unsigned DATA_IN_WIDTH = DATA_WIDTH * NUM_CH,
  parameter int unsigned IMG_SIZE      = DEFAULT_IMG_SIZE
) (
  input logic                          Clk,
  input logic                          Rst,
  featuremap_channel_packer_if.slave   bus
);

  logic                           word_done;
  logic                           drop;
  logic [DATA_WIDTH*NUM_CH-1:0]   word;
  logic                           frame_end;

  fm_state_e                state_q, state_d;
  logic [DATA_IN_WIDTH-1:0] data_out_q, data_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_partial_q, err_partial_d;

  featuremap_lane_collector #(
    .DataWidth (DATA_WIDTH),
    .NumCh     (NUM_CH)
  ) u_collector (
    .clk_i       (Clk),
    .rst_ni      (Rst),
    .data_i      (bus.data_in),
    .valid_i     (bus.valid_in),
    .sof_i       (bus.sof_in),
    .word_done_o (word_done),
    .drop_o      (drop),
    .word_o      (word)
  );

`ifdef FEATUREMAP_PACKER_FRAME_CNT_EN
  localparam int unsigned PixW = (IMG_SIZE * IMG_SIZE > 1) ? $clog2(IMG_SIZE * IMG_SIZE) : 1;
  localparam logic [PixW-1:0] PixLast = PixW'(IMG_SIZE * IMG_SIZE - 1);

  logic [PixW-1:0] pix_cnt_q, pix_cnt_d;

  // sof never coincides with an emit: the sof beat itself cannot complete a word.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (bus.valid_in && bus.sof_in) begin
      pix_cnt_d = '0;
    end else if (word_done) begin
      pix_cnt_d = (pix_cnt_q == PixLast) ? '0 : pix_cnt_q + 1'b1;
    end
  end

  assign frame_end = word_done && (pix_cnt_q == PixLast);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pix_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
    end
  end
`else
  assign frame_end = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.valid_in) state_d = StFill;
      StFill: if (frame_end) state_d = StIdle;
    endcase
  end

  always_comb begin
    data_out_d    = word_done ? word : data_out_q;
    valid_out_d   = word_done;
    frame_done_d  = frame_end;
    err_partial_d = drop;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      err_partial_q <= 1'b0;
    end else begin
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      frame_done_q  <= frame_done_d;
      err_partial_q <= err_partial_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_partial = err_partial_q;

endmodule

// File: tb/tb_featuremap_channel_packer.sv
// Directed bench for featuremap_channel_packer (NUM_CH=32, IMG_SIZE=2).
module tb_featuremap_channel_packer;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 32;
  localparam int unsigned WW = DW * NC;

  logic clk;
  logic rst_n;

  featuremap_channel_packer_if #(.DATA_WIDTH(DW), .DATA_IN_WIDTH(WW)) bus ();

  featuremap_channel_packer #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NC),
    .DATA_IN_WIDTH (WW),
    .IMG_SIZE      (2)
  ) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Output observer: counts pulses shortly after each rising edge.
  int          cyc = 0;
  int          vo_cnt = 0, fd_cnt = 0, err_cnt = 0, fd_idx = 0;
  int          last_cyc = 0, prev_cyc = 0;
  logic [WW-1:0] last_data = '0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (bus.valid_out === 1'b1) begin
      vo_cnt    = vo_cnt + 1;
      prev_cyc  = last_cyc;
      last_cyc  = cyc;
      last_data = bus.data_out;
    end
    if (bus.frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_idx = vo_cnt;
    end
    if (bus.err_partial === 1'b1) err_cnt = err_cnt + 1;
  end

  function automatic logic [WW-1:0] mk_word(input logic [31:0] base);
    logic [WW-1:0] w;
    for (int c = 0; c < int'(NC); c++) w[c*DW +: DW] = base + 32'(c);
    return w;
  endfunction

  function automatic int first_diff(input logic [WW-1:0] a, input logic [WW-1:0] b);
    for (int c = 0; c < int'(NC); c++) if (a[c*DW +: DW] !== b[c*DW +: DW]) return c;
    return -1;
  endfunction

  task automatic beat(input logic [31:0] v, input logic sof);
    @(negedge clk);
    bus.data_in  = v;
    bus.valid_in = 1'b1;
    bus.sof_in   = sof;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    bus.data_in  = '0;
  endtask

  task automatic send_pixel(input logic [31:0] base);
    for (int c = 0; c < int'(NC); c++) beat(base + 32'(c), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    bus.data_in  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [WW-1:0] zero;
    zero = '0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.data_out !== zero) begin
      n_bad++;
      $display("FAIL reset_data_out: got lane %0d nonzero, want all zero", first_diff(bus.data_out, zero));
    end
    n_cmp++;
    if ({bus.valid_out, bus.frame_done, bus.err_partial} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {bus.valid_out, bus.frame_done, bus.err_partial});
    end
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [WW-1:0] exp;
    int v0;
    do_reset();
    exp = mk_word(32'h3F80_0000);
    v0  = vo_cnt;
    send_pixel(32'h3F80_0000);
    n_cmp++;
    if (vo_cnt - v0 !== 0) begin
      n_bad++;
      $display("FAIL basic_early_valid: got %0d pulses before last beat, want 0", vo_cnt - v0);
    end
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_valid: got %b want 1", bus.valid_out);
    end
    n_cmp++;
    if (bus.data_out !== exp) begin
      n_bad++;
      $display("FAIL basic_data: lane %0d got %h want %h", first_diff(bus.data_out, exp),
               bus.data_out[first_diff(bus.data_out, exp)*DW +: DW],
               exp[first_diff(bus.data_out, exp)*DW +: DW]);
    end
    n_cmp++;
    if (bus.frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_frame_done: got %b want 0", bus.frame_done);
    end
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== exp) begin
      n_bad++;
      $display("FAIL basic_pulse_hold: valid got %b want 0, data_held %b want 1",
               bus.valid_out, bus.data_out === exp);
    end
  endtask

  task automatic test_gapped();
    logic [WW-1:0] exp;
    int v0;
    do_reset();
    exp = mk_word(32'h3F80_0000);
    v0  = vo_cnt;
    for (int c = 0; c < int'(NC) - 1; c++) begin
      beat(32'h3F80_0000 + 32'(c), 1'b0);
      idle();
    end
    beat(32'h3F80_001F, 1'b0);
    n_cmp++;
    if (vo_cnt - v0 !== 0) begin
      n_bad++;
      $display("FAIL gap_early_valid: got %0d pulses, want 0", vo_cnt - v0);
    end
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== exp) begin
      n_bad++;
      $display("FAIL gap_emit: valid got %b want 1, first bad lane %0d",
               bus.valid_out, first_diff(bus.data_out, exp));
    end
  endtask

  task automatic test_frame();
    int v0, f0;
    do_reset();
    v0 = vo_cnt;
    f0 = fd_cnt;
`ifdef FEATUREMAP_PACKER_FRAME_CNT_EN
    for (int p = 0; p < 4; p++) send_pixel(32'hA000_0000 + 32'(p << 8));
    idle();
    idle();
    n_cmp++;
    if (vo_cnt - v0 !== 4) begin
      n_bad++;
      $display("FAIL frame_pulses: got %0d want 4", vo_cnt - v0);
    end
    n_cmp++;
    if (fd_cnt - f0 !== 1 || fd_idx !== v0 + 4) begin
      n_bad++;
      $display("FAIL frame_done: got %0d pulses at emit %0d, want 1 at emit 4",
               fd_cnt - f0, fd_idx - v0);
    end
    n_cmp++;
    if (last_cyc - prev_cyc !== 32) begin
      n_bad++;
      $display("FAIL frame_spacing: got %0d cycles want 32", last_cyc - prev_cyc);
    end
    n_cmp++;
    if (bus.data_out !== mk_word(32'hA000_0300)) begin
      n_bad++;
      $display("FAIL frame_last_data: first bad lane %0d", first_diff(bus.data_out, mk_word(32'hA000_0300)));
    end
    // Second frame: pix_cnt must have wrapped, so frame_done lands on its 4th emit.
    for (int p = 4; p < 8; p++) send_pixel(32'hA000_0000 + 32'(p << 8));
    idle();
    idle();
    n_cmp++;
    if (fd_cnt - f0 !== 2 || fd_idx !== v0 + 8) begin
      n_bad++;
      $display("FAIL frame2_done: got %0d pulses, last at emit %0d, want 2 at emit 8",
               fd_cnt - f0, fd_idx - v0);
    end
    n_cmp++;
    if (last_data !== mk_word(32'hA000_0700)) begin
      n_bad++;
      $display("FAIL frame2_data: first bad lane %0d", first_diff(last_data, mk_word(32'hA000_0700)));
    end
`else
    for (int p = 0; p < 5; p++) send_pixel(32'hA000_0000 + 32'(p << 8));
    idle();
    idle();
    n_cmp++;
    if (vo_cnt - v0 !== 5) begin
      n_bad++;
      $display("FAIL nofc_pulses: got %0d want 5", vo_cnt - v0);
    end
    n_cmp++;
    if (fd_cnt - f0 !== 0) begin
      n_bad++;
      $display("FAIL nofc_frame_done: got %0d pulses want 0", fd_cnt - f0);
    end
    n_cmp++;
    if (last_cyc - prev_cyc !== 32) begin
      n_bad++;
      $display("FAIL nofc_spacing: got %0d cycles want 32", last_cyc - prev_cyc);
    end
    n_cmp++;
    if (last_data !== mk_word(32'hA000_0400)) begin
      n_bad++;
      $display("FAIL nofc_data: first bad lane %0d", first_diff(last_data, mk_word(32'hA000_0400)));
    end
`endif
  endtask

  task automatic test_sof_resync();
    logic [WW-1:0] exp;
    int v0, e0;
    do_reset();
    exp = mk_word(32'h2000_0000);
    exp[31:0] = 32'hDEAD_BEEF;
    v0 = vo_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) beat(32'h1000_0000 + 32'(i), 1'b0);
    beat(32'hDEAD_BEEF, 1'b1);
    beat(32'h2000_0001, 1'b0);
    n_cmp++;
    if (bus.err_partial !== 1'b1) begin
      n_bad++;
      $display("FAIL sof_err_timing: got %b want 1", bus.err_partial);
    end
    for (int c = 2; c < int'(NC); c++) beat(32'h2000_0000 + 32'(c), 1'b0);
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== exp) begin
      n_bad++;
      $display("FAIL sof_emit: valid got %b want 1, first bad lane %0d",
               bus.valid_out, first_diff(bus.data_out, exp));
    end
    idle();
    n_cmp++;
    if (vo_cnt - v0 !== 1 || err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL sof_counts: valid %0d err %0d, want 1 and 1", vo_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_sof_collide();
    logic [WW-1:0] exp;
    int v0, e0;
    do_reset();
    exp = mk_word(32'h5000_0000);
    exp[31:0] = 32'hCAFE_F00D;
    v0 = vo_cnt;
    e0 = err_cnt;
    for (int c = 0; c < int'(NC) - 1; c++) beat(32'h4000_0000 + 32'(c), 1'b0);
    beat(32'hCAFE_F00D, 1'b1);
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.err_partial !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_flags: valid %b err %b, want 0 and 1", bus.valid_out, bus.err_partial);
    end
    for (int c = 1; c < int'(NC); c++) beat(32'h5000_0000 + 32'(c), 1'b0);
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== exp || vo_cnt - v0 !== 1 || err_cnt - e0 !== 1) begin
      n_bad++;
      $display("FAIL collide_emit: valid %b pulses %0d err %0d bad lane %0d, want 1 1 1 -1",
               bus.valid_out, vo_cnt - v0, err_cnt - e0, first_diff(bus.data_out, exp));
    end
  endtask

  task automatic test_mid_reset();
    logic [WW-1:0] exp;
    logic [WW-1:0] zero;
    int v0, e0;
    do_reset();
    zero = '0;
    exp  = mk_word(32'h7700_0000);
    v0 = vo_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) beat(32'h6600_0000 + 32'(i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.data_out !== zero || {bus.valid_out, bus.frame_done, bus.err_partial} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_outputs: flags %b want 000, data zero %b want 1",
               {bus.valid_out, bus.frame_done, bus.err_partial}, bus.data_out === zero);
    end
    rst_n = 1'b1;
    send_pixel(32'h7700_0000);
    idle();
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== exp) begin
      n_bad++;
      $display("FAIL midrst_emit: valid %b want 1, first bad lane %0d",
               bus.valid_out, first_diff(bus.data_out, exp));
    end
    idle();
    n_cmp++;
    if (vo_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      n_bad++;
      $display("FAIL midrst_counts: valid %0d err %0d, want 1 and 0", vo_cnt - v0, err_cnt - e0);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.sof_in   = 1'b0;
    bus.data_in  = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_frame();
    test_sof_resync();
    test_sof_collide();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
